instr_imm_encoder: RTL and testbench

- Pipelined encoder that assembles 32-bit LEGv8 LDUR/STUR/CBZ/B instruction words from a kind code, register fields and a 64-bit signed offset.
- It is the inverse of the decode-stage immediate sign extension: the 64-bit offset is range-checked, truncated into the format's address field, and packed with the opcode.
- Used by the branch-fixup/program-loader path that writes instruction memory; valid/ready on both sides.

---
 rtl/instr_imm_encoder_pkg.sv | 31 +++
 rtl/instr_imm_encoder_if.sv | 26 ++
 rtl/instr_imm_encoder_imm_range_check.sv | 22 ++
 rtl/instr_imm_encoder.sv | 109 ++++++++++
 tb/tb_instr_imm_encoder.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_imm_encoder_pkg.sv
// rtl/instr_imm_encoder_pkg.sv - kind encodings, opcodes and field widths for the LEGv8 immediate encoder
package instr_imm_encoder_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    typedef enum logic [1:0] {
        KIND_LDUR = 2'd0,
        KIND_STUR = 2'd1,
        KIND_CBZ  = 2'd2,
        KIND_B    = 2'd3
    } kind_e;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [5:0] DT_ADDR_W = 6'd9;
    localparam logic [5:0] CB_ADDR_W = 6'd19;
    localparam logic [5:0] BR_ADDR_W = 6'd26;

    function automatic logic [5:0] field_width(input kind_e kind);
        case (kind)
            KIND_LDUR, KIND_STUR: field_width = DT_ADDR_W;
            KIND_CBZ:             field_width = CB_ADDR_W;
            default:              field_width = BR_ADDR_W;
        endcase
    endfunction

endpackage

// File: rtl/instr_imm_encoder_if.sv
// rtl/instr_imm_encoder_if.sv - request/response handshake bundle for the immediate encoder
interface instr_imm_encoder_if;
    import instr_imm_encoder_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_kind;
    logic [4:0]           in_rt;
    logic [4:0]           in_rn;
    logic [WORD-1:0]      in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_LEN-1:0] out_instr;
    logic                 out_range_err;

    modport slave (
        input  in_valid, in_kind, in_rt, in_rn, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_range_err
    );

    modport master (
        output in_valid, in_kind, in_rt, in_rn, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_range_err
    );

endinterface

// File: rtl/instr_imm_encoder_imm_range_check.sv
// rtl/instr_imm_encoder_imm_range_check.sv - flags an offset that does not fit a signed field of i_width bits
module instr_imm_encoder_imm_range_check
    import instr_imm_encoder_pkg::*;
(
    input  logic [WORD-1:0] i_imm,
    input  logic [5:0]      i_width,
    output logic            o_err
);

    logic [WORD-1:0] w_ext;
    logic            w_sign;

    // Representable exactly when re-extending the low bits reproduces the full value.
    always_comb begin
        w_sign = i_imm[i_width - 6'd1];
        for (int i = 0; i < WORD; i++) begin
            w_ext[i] = (i < int'(i_width)) ? i_imm[i] : w_sign;
        end
        o_err = (w_ext != i_imm);
    end

endmodule

// File: rtl/instr_imm_encoder.sv
// rtl/instr_imm_encoder.sv - two-stage LDUR/STUR/CBZ/B instruction word encoder with range-error counting
module instr_imm_encoder
    import instr_imm_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_imm_encoder_if.slave   bus,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic                 w_adv;
    logic                 w_in_fire;
    logic                 w_range_err;
    logic                 w_deliver_err;
    kind_e                w_in_kind;
    logic [5:0]           w_width;
    logic [INSTR_LEN-1:0] w_packed;

    logic                 r_s1_valid;
    kind_e                r_s1_kind;
    logic [4:0]           r_s1_rt;
    logic [4:0]           r_s1_rn;
    logic [25:0]          r_s1_field;
    logic                 r_s1_err;

    logic                 r_out_valid;
    logic [INSTR_LEN-1:0] r_out_instr;
    logic                 r_out_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    // Single enable for both stages: the pipe only moves when the output slot frees.
    assign w_adv         = !r_out_valid || bus.out_ready;
    assign w_in_fire     = bus.in_valid && w_adv;
    assign w_in_kind     = kind_e'(bus.in_kind);
    assign w_width       = field_width(w_in_kind);
    assign w_deliver_err = r_out_valid && bus.out_ready && r_out_err;

    assign bus.in_ready      = w_adv;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_instr     = r_out_instr;
    assign bus.out_range_err = r_out_err;
    assign err_count         = r_err_count;

    instr_imm_encoder_imm_range_check u_range_check (
        .i_imm   (bus.in_imm),
        .i_width (w_width),
        .o_err   (w_range_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_kind  <= KIND_LDUR;
            r_s1_rt    <= '0;
            r_s1_rn    <= '0;
            r_s1_field <= '0;
            r_s1_err   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            if (w_in_fire) begin
                r_s1_kind  <= w_in_kind;
                r_s1_rt    <= bus.in_rt;
                r_s1_rn    <= bus.in_rn;
                r_s1_field <= bus.in_imm[25:0];
                r_s1_err   <= w_range_err;
            end
        end
    end

    always_comb begin
        w_packed = '0;
        case (r_s1_kind)
            KIND_LDUR: w_packed = {OP_LDUR, r_s1_field[8:0], 2'b00, r_s1_rn, r_s1_rt};
            KIND_STUR: w_packed = {OP_STUR, r_s1_field[8:0], 2'b00, r_s1_rn, r_s1_rt};
            KIND_CBZ:  w_packed = {OP_CBZ, r_s1_field[18:0], r_s1_rt};
            KIND_B:    w_packed = {OP_B, r_s1_field};
            default:   w_packed = '0;
        endcase
    end

    // Bubbles clear out_valid but leave the last word visible on out_instr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_err   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_instr <= w_packed;
                r_out_err   <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_deliver_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// tb/tb_instr_imm_encoder.sv - scoreboard bench for the LEGv8 immediate encoder
module tb_instr_imm_encoder;
    import instr_imm_encoder_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] err_count;

    int   n_tests = 0;
    int   n_fail = 0;
    int   n_delivered = 0;
    exp_t sb[$];

    instr_imm_encoder_if bus();

    instr_imm_encoder #(.ERR_CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int kind, input logic [4:0] rt, input logic [4:0] rn,
                                   input longint imm);
        exp_t   e;
        longint lim;
        int     n;
        n     = (kind < 2) ? 9 : ((kind == 2) ? 19 : 26);
        lim   = longint'(1) << (n - 1);
        e.err = (imm < -lim) || (imm >= lim);
        case (kind)
            0:       e.instr = {11'h7C2, imm[8:0], 2'b00, rn, rt};
            1:       e.instr = {11'h7C0, imm[8:0], 2'b00, rn, rt};
            2:       e.instr = {8'hB4, imm[18:0], rt};
            default: e.instr = {6'h05, imm[25:0]};
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_word: got instr=%h err=%b, required no word", bus.out_instr, bus.out_range_err);
            end else begin
                e = sb.pop_front();
                n_delivered++;
                if ({bus.out_instr, bus.out_range_err} !== e) begin
                    n_fail++;
                    $display("FAIL out_word: got instr=%h err=%b, required instr=%h err=%b",
                             bus.out_instr, bus.out_range_err, e.instr, e.err);
                end
            end
        end
    end

    task automatic send(input int kind, input logic [4:0] rt, input logic [4:0] rn, input longint imm);
        int budget;
        budget        = 0;
        bus.in_valid  = 1'b1;
        bus.in_kind   = kind[1:0];
        bus.in_rt     = rt;
        bus.in_rn     = rn;
        bus.in_imm    = imm;
        @(negedge clk);
        while (!bus.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b, required 1", bus.in_ready);
        end else begin
            sb.push_back(model(kind, rt, rn, imm));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words pending, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.out_valid, bus.out_instr, bus.out_range_err, err_count} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b instr=%h err=%b cnt=%h, required all 0",
                     bus.out_valid, bus.out_instr, bus.out_range_err, err_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ldur();
        send(0, 5'd1, 5'd2, -4);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ldur_latency1: out_valid=%b, required 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({bus.out_valid, bus.out_instr, bus.out_range_err} !== {1'b1, 32'hF85FC041, 1'b0}) begin
            n_fail++;
            $display("FAIL ldur_word: valid=%b instr=%h err=%b, required 1 F85FC041 0",
                     bus.out_valid, bus.out_instr, bus.out_range_err);
        end
        drain();
    endtask

    task automatic test_cbz();
        send(2, 5'd3, 5'd0, 64'sh3FFFF);
        send(2, 5'd3, 5'd0, 64'sh40000);
        n_tests++;
        if (bus.out_instr !== 32'hB47FFFE3 || bus.out_range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cbz_max: instr=%h err=%b, required B47FFFE3 0", bus.out_instr, bus.out_range_err);
        end
        drain();
        n_tests++;
        if ({bus.out_valid, bus.out_instr, err_count} !== {1'b0, 32'hB4800003, 16'd1}) begin
            n_fail++;
            $display("FAIL cbz_overflow: valid=%b instr=%h cnt=%0d, required 0 B4800003 1",
                     bus.out_valid, bus.out_instr, err_count);
        end
    endtask

    task automatic test_branch();
        send(3, 5'd0, 5'd0, -1);
        send(3, 5'd9, 5'd9, -(longint'(1) << 25));
        n_tests++;
        if (bus.out_instr !== 32'h17FFFFFF || bus.out_range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b_minus1: instr=%h err=%b, required 17FFFFFF 0", bus.out_instr, bus.out_range_err);
        end
        send(3, 5'd0, 5'd0, longint'(1) << 25);
        n_tests++;
        if (bus.out_instr !== 32'h16000000 || bus.out_range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b_min: instr=%h err=%b, required 16000000 0", bus.out_instr, bus.out_range_err);
        end
        drain();
        n_tests++;
        if (err_count !== 16'd2) begin
            n_fail++;
            $display("FAIL b_overflow_count: got %0d, required 2", err_count);
        end
    endtask

    task automatic test_back_to_back();
        int   base;
        exp_t held;
        base = n_delivered;
        held = model(1, 5'd7, 5'd8, -256);
        fork
            begin
                send(0, 5'd5, 5'd6, 255);
                send(1, 5'd7, 5'd8, -256);
                send(2, 5'd9, 5'd0, -262144);
                send(1, 5'd10, 5'd11, 256);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    n_tests++;
                    if ({bus.in_ready, bus.out_valid, bus.out_instr, bus.out_range_err} !== {2'b01, held}) begin
                        n_fail++;
                        $display("FAIL stall_hold: rdy=%b valid=%b instr=%h err=%b, required 0 1 %h %b",
                                 bus.in_ready, bus.out_valid, bus.out_instr, bus.out_range_err,
                                 held.instr, held.err);
                    end
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        n_tests++;
        if (n_delivered - base !== 4 || err_count !== 16'd3) begin
            n_fail++;
            $display("FAIL burst_count: delivered=%0d cnt=%0d, required 4 3", n_delivered - base, err_count);
        end
    endtask

    task automatic test_err_saturation();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        n_tests++;
        if (err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_idle: got %h, required 0000", err_count);
        end
        for (int i = 0; i < 65535; i++) send(3, 5'd0, 5'd0, longint'(1) << 26);
        drain();
        n_tests++;
        if (err_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_reach: got %h, required FFFF", err_count);
        end
        send(3, 5'd0, 5'd0, -(longint'(1) << 26) - 1);
        drain();
        n_tests++;
        if (err_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %h, required FFFF", err_count);
        end
        bus.out_ready = 1'b0;
        send(0, 5'd4, 5'd4, 256);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        err_clr       = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        n_tests++;
        if (err_count !== 16'd0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL clr_wins: cnt=%h pending=%0d, required 0000 0", err_count, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        send(0, 5'd1, 5'd1, 8);
        send(0, 5'd2, 5'd2, 16);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_full: valid=%b rdy=%b, required 1 0", bus.out_valid, bus.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%b, required 0", bus.out_valid);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send(1, 5'd3, 5'd4, -8);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_early: out_valid=%b, required 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({bus.out_valid, bus.out_instr, bus.out_range_err} !== {1'b1, 32'hF81F8083, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_word: valid=%b instr=%h err=%b, required 1 F81F8083 0",
                     bus.out_valid, bus.out_instr, bus.out_range_err);
        end
        drain();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_kind   = 2'd0;
        bus.in_rt     = 5'd0;
        bus.in_rn     = 5'd0;
        bus.in_imm    = 64'd0;
        bus.out_ready = 1'b1;
        test_reset();
        test_ldur();
        test_cbz();
        test_branch();
        test_back_to_back();
        test_err_saturation();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
